control: RTL and testbench
==========================

Name: control

Overview:
- Main control decoder for the single-cycle-style MIPS32 datapath.
- Takes the 6-bit primary opcode field (instruction bits 31:26) and produces the datapath steering and enable signals for R-type, lw, sw and beq.
- It also produces the 2-bit ALUOp code consumed by the ALU control block.
- Outputs are registered on the single system clock so downstream stages see glitch-free controls.

Parameters:
- None. The opcode encodings are fixed constants: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- instru  input  6  instruction opcode field (bits 31:26)
- RegDest  output  1  destination register select: 1 = rd, 0 = rt
- FuenteALU  output  1  ALU B-operand select: 1 = sign-extended immediate, 0 = register rt
- MemaReg  output  1  write-back source: 1 = data memory, 0 = ALU result
- EscrReg  output  1  register file write enable
- LeerMem  output  1  data memory read enable
- EscrMem  output  1  data memory write enable
- SaltoCond  output  1  conditional branch (beq) enable
- ALUOp1  output  1  ALUOp bit 1
- ALUOp0  output  1  ALUOp bit 0
- InstrValida  output  1  1 = opcode is one of the four supported encodings

Behaviour:
- Reset: while reset=1, every output is 0, asynchronously and without waiting for a clock edge. This is the NOP state: no register write, no memory access, no branch.
- Latency: on each rising clk edge with reset=0, the outputs load the decode of the current instru. Outputs are therefore valid 1 cycle after instru is presented. They hold between edges.
- Decode table, listed as RegDest, FuenteALU, MemaReg, EscrReg, LeerMem, EscrMem, SaltoCond, ALUOp1, ALUOp0, InstrValida:
  - 000000 (R-type): 1,0,0,1,0,0,0,1,0,1
  - 100011 (lw): 0,1,1,1,1,0,0,0,0,1
  - 101011 (sw): 0,1,0,0,0,1,0,0,0,1
  - 000100 (beq): 0,0,0,0,0,0,1,0,1,1
  - Any other opcode: all 0, including InstrValida=0.
- Don't-care fields of the textbook table are fixed at 0. RegDest and MemaReg are 0 for sw; RegDest and MemaReg are 0 for beq.
- Unknown inputs: if any bit of instru is X or Z, the decode is the illegal-opcode result (all 0). Outputs must never go X after reset. Use an explicit default arm, not a casex/casez wildcard match.
- Invariants that must hold every cycle:
  - EscrMem and LeerMem are never both 1.
  - EscrReg and EscrMem are never both 1.
  - SaltoCond=1 implies EscrReg=0 and EscrMem=0.
  - ALUOp 2'b11 is never produced.
- Reset release: the first rising edge after reset deasserts loads the decode of the instru present at that edge.
- Reset asserted mid-operation: outputs clear immediately, regardless of clock phase.
- No internal state other than the output registers.

Test Plan:
- Reset: assert reset with instru=6'b000000 -> all outputs 0 immediately, before any clk edge. Deassert, clock once -> RegDest=1, EscrReg=1, ALUOp1=1, InstrValida=1, all others 0.
- Full sweep: drive 6'b000000, 6'b100011, 6'b101011, 6'b000100, one per clock. Each cycle's outputs must match the decode table exactly, with 1-cycle lag. Example: lw -> FuenteALU, MemaReg, EscrReg, LeerMem and InstrValida = 1, everything else 0.
- Unknown opcode: instru=6'bxxxxxx, and separately 6'b111111 and 6'b000010 -> after the next edge all outputs are 0 and none is X.
- Back-to-back transition: sw followed by beq -> EscrMem drops 1→0 and SaltoCond rises 0→1 on the same edge; ALUOp goes 00→01.
- Asynchronous mid-cycle reset: with lw decoded, pulse reset between clock edges -> outputs go to 0 within the pulse and stay 0 until the first edge after release.
- Exhaustive check: loop all 64 opcodes -> InstrValida=1 exactly for the four legal encodings, and the invariants hold on every cycle.

Source files
------------

// File: rtl/control_if.sv
`default_nettype none
// ============================================================================
// Module      : control_if
// Description : Opcode/control bundle between the instruction source and the
//               main control decoder.
//               master : drives instru, observes the decoded controls
//               slave  : observes instru, drives the decoded controls
//               Signals: instru[5:0], RegDest, FuenteALU, MemaReg, EscrReg,
//               LeerMem, EscrMem, SaltoCond, ALUOp1, ALUOp0, InstrValida
// Revision    : 1.0 - initial release
// ============================================================================
interface control_if;
   logic [5:0] instru;
   logic       RegDest;
   logic       FuenteALU;
   logic       MemaReg;
   logic       EscrReg;
   logic       LeerMem;
   logic       EscrMem;
   logic       SaltoCond;
   logic       ALUOp1;
   logic       ALUOp0;
   logic       InstrValida;

   modport master (
      output instru,
      input  RegDest, FuenteALU, MemaReg, EscrReg, LeerMem,
      input  EscrMem, SaltoCond, ALUOp1, ALUOp0, InstrValida
   );

   modport slave (
      input  instru,
      output RegDest, FuenteALU, MemaReg, EscrReg, LeerMem,
      output EscrMem, SaltoCond, ALUOp1, ALUOp0, InstrValida
   );
endinterface
`default_nettype wire

// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module      : control
// Description : Main control decoder for the MIPS32 datapath. Decodes the
//               primary opcode (R-type, lw, sw, beq) into registered
//               datapath steering/enable signals and the 2-bit ALUOp.
//               Ports: clk   - system clock, rising edge
//                      reset - asynchronous active-high reset (NOP state)
//                      bus   - control_if.slave (instru in, controls out)
// Revision    : 1.0 - initial release
// ============================================================================
module control (
   input  wire logic clk,
   input  wire logic reset,
   control_if.slave  bus
);

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;

   // Control word, MSB first:
   // RegDest, FuenteALU, MemaReg, EscrReg, LeerMem, EscrMem, SaltoCond,
   // ALUOp1, ALUOp0, InstrValida
   localparam logic [9:0] c_ctl_rtype = 10'b1001000101;
   localparam logic [9:0] c_ctl_lw    = 10'b0111100001;
   localparam logic [9:0] c_ctl_sw    = 10'b0100010001;
   localparam logic [9:0] c_ctl_beq   = 10'b0000001011;
   localparam logic [9:0] c_ctl_nop   = 10'b0000000000;

   logic [9:0] w_dec;
   logic [9:0] r_ctl;

   // Exact-match case: an opcode carrying X/Z bits matches no legal item and
   // falls into the default arm, yielding the NOP word.
   always_comb begin
      w_dec = c_ctl_nop;
      case (bus.instru)
         c_op_rtype: w_dec = c_ctl_rtype;
         c_op_lw:    w_dec = c_ctl_lw;
         c_op_sw:    w_dec = c_ctl_sw;
         c_op_beq:   w_dec = c_ctl_beq;
         default:    w_dec = c_ctl_nop;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ctl <= c_ctl_nop;
      end else begin
         r_ctl <= w_dec;
      end
   end

   assign bus.RegDest     = r_ctl[9];
   assign bus.FuenteALU   = r_ctl[8];
   assign bus.MemaReg     = r_ctl[7];
   assign bus.EscrReg     = r_ctl[6];
   assign bus.LeerMem     = r_ctl[5];
   assign bus.EscrMem     = r_ctl[4];
   assign bus.SaltoCond   = r_ctl[3];
   assign bus.ALUOp1      = r_ctl[2];
   assign bus.ALUOp0      = r_ctl[1];
   assign bus.InstrValida = r_ctl[0];

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_control
// Description : Self-checking bench for the main control decoder. Expected
//               control words come from a rule-based model of the opcode
//               semantics; stimulus mixes directed and $urandom patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   control_if bus ();

   control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed outputs packed MSB first in the same field order as the model.
   function automatic logic [9:0] get_out();
      return {bus.RegDest, bus.FuenteALU, bus.MemaReg, bus.EscrReg,
              bus.LeerMem, bus.EscrMem, bus.SaltoCond, bus.ALUOp1,
              bus.ALUOp0, bus.InstrValida};
   endfunction

   // Reference model: each control derived from what the instruction class
   // needs to do, not from a stored table.
   function automatic logic [9:0] model(input logic [5:0] op);
      logic rt, ld, st, br;
      if ($isunknown(op)) return 10'd0;
      rt = (op == 6'd0);
      ld = (op == 6'd35);
      st = (op == 6'd43);
      br = (op == 6'd4);
      // RegDest: only R-type writes rd; FuenteALU: address calc uses imm;
      // MemaReg: only loads write back memory data; EscrReg: R-type and lw;
      // ALUOp: 10 for R-type funct decode, 01 for beq subtract, 00 for add.
      return {rt, ld | st, ld, rt | ld, ld, st, br, rt, br,
              rt | ld | st | br};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [9:0] got;
      bus.instru = 6'b000000;
      reset = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      got = get_out();
      checks++;
      if (got !== 10'd0) begin
         errors++;
         $display("FAIL reset_async got=%b want=%b", got, 10'd0);
      end
      tick();
      got = get_out();
      checks++;
      if (got !== 10'd0) begin
         errors++;
         $display("FAIL reset_hold got=%b want=%b", got, 10'd0);
      end
      reset = 1'b0;
      tick();
      got = get_out();
      checks++;
      if (got !== 10'b1001000101) begin
         errors++;
         $display("FAIL reset_release got=%b want=%b", got, 10'b1001000101);
      end
   endtask

   task automatic test_sweep();
      logic [5:0] ops [4];
      logic [9:0] got;
      ops[0] = 6'b000000; ops[1] = 6'b100011;
      ops[2] = 6'b101011; ops[3] = 6'b000100;
      for (int i = 0; i < 4; i++) begin
         bus.instru = ops[i];
         tick();
         got = get_out();
         checks++;
         if (got !== model(ops[i])) begin
            errors++;
            $display("FAIL sweep op=%b got=%b want=%b", ops[i], got, model(ops[i]));
         end
      end
      // lw spelled out independently of the model
      bus.instru = 6'b100011;
      tick();
      got = get_out();
      checks++;
      if (got !== 10'b0111100001) begin
         errors++;
         $display("FAIL sweep_lw_literal got=%b want=%b", got, 10'b0111100001);
      end
   endtask

   task automatic test_unknown();
      logic [5:0] ops [3];
      logic [9:0] got;
      logic [9:0] want;
      ops[0] = 6'bxxxxxx; ops[1] = 6'b111111; ops[2] = 6'b000010;
      for (int i = 0; i < 3; i++) begin
         bus.instru = 6'b100011;
         tick();
         bus.instru = ops[i];
         // model of the stimulus as actually held (2-state tools collapse X)
         want = model(bus.instru);
         tick();
         got = get_out();
         checks++;
         if (got !== want || $isunknown(got)) begin
            errors++;
            $display("FAIL unknown_op idx=%0d got=%b want=%b", i, got, want);
         end
      end
      bus.instru = 6'b111111;
      tick();
      got = get_out();
      checks++;
      if (got !== 10'd0) begin
         errors++;
         $display("FAIL unknown_allones got=%b want=%b", got, 10'd0);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] got;
      bus.instru = 6'b101011;
      tick();
      got = get_out();
      checks++;
      if (bus.EscrMem !== 1'b1 || bus.SaltoCond !== 1'b0 ||
          {bus.ALUOp1, bus.ALUOp0} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_sw got=%b want=%b", got, model(6'b101011));
      end
      bus.instru = 6'b000100;
      tick();
      got = get_out();
      checks++;
      if (bus.EscrMem !== 1'b0 || bus.SaltoCond !== 1'b1 ||
          {bus.ALUOp1, bus.ALUOp0} !== 2'b01 || got !== model(6'b000100)) begin
         errors++;
         $display("FAIL b2b_beq got=%b want=%b", got, model(6'b000100));
      end
   endtask

   task automatic test_async_reset();
      logic [9:0] got;
      bus.instru = 6'b100011;
      tick();
      got = get_out();
      checks++;
      if (got !== model(6'b100011)) begin
         errors++;
         $display("FAIL areset_pre got=%b want=%b", got, model(6'b100011));
      end
      #2;
      reset = 1'b1;
      #1;
      got = get_out();
      checks++;
      if (got !== 10'd0) begin
         errors++;
         $display("FAIL areset_mid got=%b want=%b", got, 10'd0);
      end
      #2;
      reset = 1'b0;
      #1;
      got = get_out();
      checks++;
      if (got !== 10'd0) begin
         errors++;
         $display("FAIL areset_after_release got=%b want=%b", got, 10'd0);
      end
      tick();
      got = get_out();
      checks++;
      if (got !== model(6'b100011)) begin
         errors++;
         $display("FAIL areset_reload got=%b want=%b", got, model(6'b100011));
      end
   endtask

   task automatic test_exhaustive();
      logic [9:0] got;
      int nvalid;
      nvalid = 0;
      for (int i = 0; i < 64; i++) begin
         bus.instru = 6'(i);
         tick();
         got = get_out();
         checks++;
         if (got !== model(6'(i))) begin
            errors++;
            $display("FAIL exh op=%b got=%b want=%b", 6'(i), got, model(6'(i)));
         end
         checks++;
         if ((bus.EscrMem & bus.LeerMem) || (bus.EscrReg & bus.EscrMem) ||
             (bus.SaltoCond & (bus.EscrReg | bus.EscrMem)) ||
             (bus.ALUOp1 & bus.ALUOp0)) begin
            errors++;
            $display("FAIL exh_invariant op=%b got=%b", 6'(i), got);
         end
         if (bus.InstrValida === 1'b1) nvalid++;
      end
      checks++;
      if (nvalid != 4) begin
         errors++;
         $display("FAIL exh_valid_count got=%0d want=4", nvalid);
      end
   endtask

   task automatic test_random();
      logic [5:0] legal [4];
      logic [5:0] op;
      logic [9:0] got;
      legal[0] = 6'd0; legal[1] = 6'd35; legal[2] = 6'd43; legal[3] = 6'd4;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 0) op = legal[$urandom_range(0, 3)];
         else                           op = 6'($urandom_range(0, 63));
         bus.instru = op;
         tick();
         got = get_out();
         checks++;
         if (got !== model(op)) begin
            errors++;
            $display("FAIL rand n=%0d op=%b got=%b want=%b", n, op, got, model(op));
         end
         checks++;
         if ((bus.EscrMem & bus.LeerMem) || (bus.EscrReg & bus.EscrMem) ||
             (bus.SaltoCond & (bus.EscrReg | bus.EscrMem)) ||
             (bus.ALUOp1 & bus.ALUOp0)) begin
            errors++;
            $display("FAIL rand_invariant n=%0d got=%b", n, got);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      bus.instru = 6'b000000;
      test_reset();
      test_sweep();
      test_unknown();
      test_back_to_back();
      test_async_reset();
      test_exhaustive();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
